// File: rtl/sd_sector_write_scheduler.sv
// Packs UART bytes into 16-bit words in a two-sector ping-pong buffer and writes
// full (or idle-flushed) sectors to the SD controller at consecutive sector addresses.
module sd_sector_write_scheduler #(
  parameter logic [31:0] START_ADDR       = 32'h0000_0000,
  parameter int          WORDS_PER_SECTOR = 256,
  parameter int          FLUSH_TIMEOUT    = 50_000_000,
  parameter logic [7:0]  PAD_BYTE         = 8'hFF
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        rx_flag,
  input  logic [7:0]  rx_data,
  input  logic        wr_busy,
  input  logic        wr_req,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [15:0] wr_data,
  output logic        overflow,
  output logic [31:0] sectors_written
);

  localparam int AW = $clog2(WORDS_PER_SECTOR);
  localparam int CW = AW + 2;
  localparam int IW = AW + 1;
  localparam logic [CW-1:0] FULL_BYTES = CW'(2 * WORDS_PER_SECTOR);
  localparam logic [CW-1:0] LAST_BYTE  = CW'(2 * WORDS_PER_SECTOR - 1);
  localparam logic [IW-1:0] RD_END     = IW'(WORDS_PER_SECTOR);
  localparam logic [31:0]   TO_LAST    = 32'(FLUSH_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, XFER, DONE} state_t;

  state_t         state_r, state_next;
  logic [15:0]    mem [0:2*WORDS_PER_SECTOR-1];
  logic [1:0]     full_r;
  logic [CW-1:0]  cnt_r [0:1];
  logic [CW-1:0]  bcnt_r;
  logic           fill_sel_r, rd_sel_r, rd_next_r, phase_lo_r;
  logic [7:0]     hi_r;
  logic [IW-1:0]  rd_idx_r;
  logic [31:0]    tcnt_r;

  logic           fill_open_s, byte_acc_s, sector_done_s, flush_s, close_s;
  logic           release_s, other_s, other_free_s;
  logic           mem_we_s;
  logic [AW:0]    mem_waddr_s;
  logic [15:0]    mem_wdata_s, rd_word_s, rd_data_s;
  logic [CW-1:0]  rd_bi_s, rd_cnt_s;

  // Fill-side control: a buffer closes when its last byte lands or when it idles out.
  always_comb begin
    fill_open_s   = !full_r[fill_sel_r];
    byte_acc_s    = rx_flag && fill_open_s;
    sector_done_s = byte_acc_s && (bcnt_r == LAST_BYTE);
    flush_s       = !rx_flag && fill_open_s && (bcnt_r != {CW{1'b0}}) && (tcnt_r == TO_LAST);
    close_s       = sector_done_s || flush_s;
    release_s     = (state_r == DONE);
    other_s       = ~fill_sel_r;
    other_free_s  = !full_r[other_s] || (release_s && (rd_sel_r == other_s));
  end

  // Buffer write port: a packed word, or the odd trailing byte padded on flush.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = {fill_sel_r, bcnt_r[AW:1]};
    mem_wdata_s = {hi_r, PAD_BYTE};
    if (byte_acc_s && phase_lo_r) begin
      mem_we_s    = 1'b1;
      mem_wdata_s = {hi_r, rx_data};
    end else if (flush_s && bcnt_r[0]) begin
      mem_we_s = 1'b1;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Buffer read port: bytes at or beyond the recorded count read as padding.
  always_comb begin
    rd_word_s = mem[{rd_sel_r, rd_idx_r[AW-1:0]}];
    rd_bi_s   = {rd_idx_r, 1'b0};
    rd_cnt_s  = cnt_r[rd_sel_r];
    rd_data_s = rd_word_s;
    if (rd_bi_s >= rd_cnt_s) begin
      rd_data_s[15:8] = PAD_BYTE;
    end else begin
      rd_data_s[15:8] = rd_word_s[15:8];
    end
    if ((rd_bi_s + CW'(1)) >= rd_cnt_s) begin
      rd_data_s[7:0] = PAD_BYTE;
    end else begin
      rd_data_s[7:0] = rd_word_s[7:0];
    end
  end

  // Sector storage.
  always_ff @(posedge sys_clk) begin
    if (mem_we_s) mem[mem_waddr_s] <= mem_wdata_s;
  end

  // Fill pointer, byte packing, idle timeout and buffer ownership.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      full_r     <= 2'b00;
      cnt_r[0]   <= {CW{1'b0}};
      cnt_r[1]   <= {CW{1'b0}};
      bcnt_r     <= {CW{1'b0}};
      fill_sel_r <= 1'b0;
      phase_lo_r <= 1'b0;
      hi_r       <= 8'h00;
      tcnt_r     <= 32'h0000_0000;
      overflow   <= 1'b0;
    end else begin
      if (byte_acc_s) begin
        if (!phase_lo_r) hi_r <= rx_data;
        phase_lo_r <= ~phase_lo_r;
      end
      if (rx_flag && !fill_open_s) overflow <= 1'b1;
      if (rx_flag || close_s || !fill_open_s || (bcnt_r == {CW{1'b0}})) begin
        tcnt_r <= 32'h0000_0000;
      end else begin
        tcnt_r <= tcnt_r + 32'd1;
      end
      if (close_s) begin
        full_r[fill_sel_r] <= 1'b1;
        cnt_r[fill_sel_r]  <= sector_done_s ? FULL_BYTES : bcnt_r;
        bcnt_r             <= {CW{1'b0}};
        phase_lo_r         <= 1'b0;
        if (other_free_s) fill_sel_r <= other_s;
      end else begin
        if (byte_acc_s) bcnt_r <= bcnt_r + CW'(1);
        // Both were full: the buffer just released becomes the fill buffer.
        if (release_s && !fill_open_s) fill_sel_r <= rd_sel_r;
      end
      if (release_s) full_r[rd_sel_r] <= 1'b0;
    end
  end

  // Write sequencer state register.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_r <= IDLE;
    else         state_r <= state_next;
  end

  // Write sequencer next state; buffers close alternately, so rd_next_r is the oldest.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (full_r[rd_next_r] && !wr_busy) state_next = START;
        else                               state_next = IDLE;
      end
      START:     state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (wr_busy) state_next = XFER;
        else         state_next = WAIT_BUSY;
      end
      XFER: begin
        if (!wr_busy) state_next = DONE;
        else          state_next = XFER;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Drain-side datapath and SD controller outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_en           <= 1'b0;
      wr_addr         <= START_ADDR;
      wr_data         <= 16'h0000;
      sectors_written <= 32'h0000_0000;
      rd_sel_r        <= 1'b0;
      rd_next_r       <= 1'b0;
      rd_idx_r        <= {IW{1'b0}};
    end else begin
      wr_en <= (state_next == START);
      if ((state_r == IDLE) && (state_next == START)) begin
        rd_sel_r  <= rd_next_r;
        rd_next_r <= ~rd_next_r;
      end
      if (state_r == START) rd_idx_r <= {IW{1'b0}};
      if ((state_r == XFER) && wr_req) begin
        wr_data <= rd_data_s;
        if (rd_idx_r != RD_END) rd_idx_r <= rd_idx_r + IW'(1);
      end
      if (release_s) begin
        wr_addr         <= wr_addr + 32'd1;
        sectors_written <= sectors_written + 32'd1;
      end
    end
  end

endmodule
